// File: rtl/gemm_pkg.sv
// Shared GEMM tile constants and sequencer state encoding.
// Imported by the sequencer, feeders and array top.
package gemm_pkg;

    localparam int GEMM_N     = 4;
    localparam int GEMM_DRAIN = 3 * GEMM_N - 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FEED   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_UNLOAD = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/gemm_seq_ctrl.sv
// Tile-pass sequencer: feed, drain, row-by-row unload, done.
// All outputs come straight from flops.
module gemm_seq_ctrl
    import gemm_pkg::*;
#(
    parameter int N            = GEMM_N,
    parameter int DRAIN_CYCLES = GEMM_DRAIN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic                 rden,
    output logic                 acc_clr,
    output logic                 out_rd_en,
    output logic [$clog2(N)-1:0] out_row,
    output logic                 busy,
    output logic                 done,
    output logic                 start_err
);

    localparam int MAXL = (N > DRAIN_CYCLES) ? N : DRAIN_CYCLES;
    localparam int CW   = $clog2(MAXL + 1);
    localparam int RW   = $clog2(N);

    localparam logic [CW-1:0] FEED_LAST  = CW'(N - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic            rden_q;
    logic            acc_clr_q;
    logic            out_rd_en_q;
    logic [RW-1:0]   out_row_q;
    logic            busy_q;
    logic            done_q;
    logic            start_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rden_q      <= 1'b0;
            acc_clr_q   <= 1'b0;
            out_rd_en_q <= 1'b0;
            out_row_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
        end else begin
            acc_clr_q   <= 1'b0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
            if (abort && state_q != ST_IDLE) begin
                state_q     <= ST_IDLE;
                cnt_q       <= '0;
                rden_q      <= 1'b0;
                out_rd_en_q <= 1'b0;
                out_row_q   <= '0;
                busy_q      <= 1'b0;
            end else begin
                start_err_q <= start && (state_q != ST_IDLE);
                unique case (state_q)
                    ST_IDLE: begin
                        // abort in IDLE still vetoes a start
                        if (start && !abort) begin
                            state_q   <= ST_FEED;
                            cnt_q     <= '0;
                            rden_q    <= 1'b1;
                            acc_clr_q <= 1'b1;
                            busy_q    <= 1'b1;
                        end
                    end
                    ST_FEED: begin
                        if (cnt_q == FEED_LAST) begin
                            state_q <= ST_DRAIN;
                            cnt_q   <= '0;
                            rden_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    ST_DRAIN: begin
                        if (cnt_q == DRAIN_LAST) begin
                            state_q     <= ST_UNLOAD;
                            cnt_q       <= '0;
                            out_rd_en_q <= 1'b1;
                            out_row_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    ST_UNLOAD: begin
                        if (cnt_q == FEED_LAST) begin
                            state_q     <= ST_DONE;
                            cnt_q       <= '0;
                            out_rd_en_q <= 1'b0;
                            out_row_q   <= '0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            cnt_q     <= cnt_q + CW'(1);
                            out_row_q <= out_row_q + RW'(1);
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign rden      = rden_q;
    assign acc_clr   = acc_clr_q;
    assign out_rd_en = out_rd_en_q;
    assign out_row   = out_row_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign start_err = start_err_q;

endmodule

// File: tb/tb_gemm_seq_ctrl.sv
// Bench for gemm_seq_ctrl: default and N=2/DRAIN=1 instances
// driven together and compared against a pass-cycle model.
module tb_gemm_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;

    logic       a_rden, a_acc, a_ord, a_busy, a_done, a_serr;
    logic [1:0] a_row;
    logic       b_rden, b_acc, b_ord, b_busy, b_done, b_serr;
    logic [0:0] b_row;

    always #5 clk = ~clk;

    gemm_seq_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rden(a_rden), .acc_clr(a_acc), .out_rd_en(a_ord),
        .out_row(a_row), .busy(a_busy), .done(a_done),
        .start_err(a_serr)
    );

    gemm_seq_ctrl #(.N(2), .DRAIN_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rden(b_rden), .acc_clr(b_acc), .out_rd_en(b_ord),
        .out_row(b_row), .busy(b_busy), .done(b_done),
        .start_err(b_serr)
    );

    int checks = 0;
    int errors = 0;

    // k = cycle number within the current pass (0 = idle)
    int ka = 0, kb = 0;
    bit ea = 0, eb = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n, input int d, input bit st,
                        input bit ab, inout int k, inout bit e);
        if (k == 0) begin
            e = 0;
            if (st && !ab) k = 1;
        end else if (ab) begin
            k = 0;
            e = 0;
        end else begin
            e = st;
            k = (k == 2*n + d + 1) ? 0 : k + 1;
        end
    endtask

    task automatic check_one(input string p, input int n, input int d,
                             input int k, input bit e,
                             input bit rd, input bit ac, input bit od,
                             input int row, input bit bz, input bit dn,
                             input bit se);
        bit unl;
        unl = (k >= n + d + 1) && (k <= 2*n + d);
        chk({p, "rden"},      rd,  int'(k >= 1 && k <= n));
        chk({p, "acc_clr"},   ac,  int'(k == 1));
        chk({p, "out_rd_en"}, od,  int'(unl));
        chk({p, "out_row"},   row, unl ? k - n - d - 1 : 0);
        chk({p, "busy"},      bz,  int'(k >= 1 && k <= 2*n + d));
        chk({p, "done"},      dn,  int'(k == 2*n + d + 1));
        chk({p, "start_err"}, se,  int'(e));
    endtask

    task automatic check_all();
        check_one("a.", 4, 10, ka, ea, a_rden, a_acc, a_ord,
                  int'(a_row), a_busy, a_done, a_serr);
        check_one("b.", 2, 1, kb, eb, b_rden, b_acc, b_ord,
                  int'(b_row), b_busy, b_done, b_serr);
    endtask

    task automatic cyc(input bit st, input bit ab);
        start = st;
        abort = ab;
        @(posedge clk);
        step(4, 10, st, ab, ka, ea);
        step(2, 1, st, ab, kb, eb);
        @(negedge clk);
        check_all();
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        ka = 0; kb = 0; ea = 0; eb = 0;
        #1 check_all();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // single pass
        cyc(1, 0);
        repeat (24) cyc(0, 0);

        // held start: back-to-back passes
        repeat (40) cyc(1, 0);
        repeat (22) cyc(0, 0);

        // start during DRAIN
        cyc(1, 0);
        for (int i = 1; i <= 24; i++) cyc(i == 8, 0);

        // abort mid-UNLOAD, then a clean pass
        cyc(1, 0);
        for (int i = 1; i <= 24; i++) cyc(0, i == 16);
        cyc(1, 0);
        repeat (22) cyc(0, 0);

        // abort and start together in IDLE
        cyc(1, 1);
        repeat (3) cyc(0, 0);

        // async reset mid-FEED
        cyc(1, 0);
        cyc(0, 0);
        async_reset();
        repeat (5) cyc(0, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(399) == 0) async_reset();
            cyc($urandom_range(7) == 0, $urandom_range(29) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
